dot_product_sequencer: RTL and testbench
========================================

Name: dot_product_sequencer

Overview:
- Upstream/downstream wrapper stage for the scalar matrix_multiplier in the AI datapath.
- Holds two operand vectors, A and B, in local register buffers.
- On a command, it issues one element pair at a time to the multiplier over its start/done handshake and accumulates the signed products.
- Returns one 32-bit dot-product result per command over a valid/ready handshake.

Parameters:
- VEC_LEN, 8, number of entries in each operand buffer (power of two, 2..64).
- IDX_W, $clog2(VEC_LEN), width of the element index and address.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  buffer write strobe.
- wr_sel  input  1  0 = write buffer A, 1 = write buffer B.
- wr_addr  input  IDX_W  buffer entry index.
- wr_data  input  32  signed element value.
- cmd_valid  input  1  dot-product request.
- cmd_len  input  IDX_W+1  number of elements to process.
- cmd_ready  output  1  high only in IDLE.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_a  output  32  operand A to the multiplier.
- mul_b  output  32  operand B to the multiplier.
- mul_done  input  1  multiplier completion pulse.
- mul_result  input  32  multiplier product, stable when mul_done is high.
- res_valid  output  1  result available.
- res_data  output  32  accumulated dot product.
- res_ready  input  1  consumer accepts the result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; element index and accumulator clear to 0.
  - All outputs go to 0 except cmd_ready, which is 1.
  - Buffer contents reset to 0.
- Buffer writes:
  - Accepted in any state, including while a command is running.
  - A write to an entry not yet consumed by the running command affects that command. The bench must not rely on this.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_valid sampled high: latch len = min(cmd_len, VEC_LEN), clear index and accumulator.
  - len == 0: go to RESP with res_data = 0.
  - Otherwise: go to ISSUE.
- ISSUE:
  - Drive mul_start = 1 for exactly one cycle, with mul_a = A[idx] and mul_b = B[idx] registered.
  - Next state: WAIT.
  - mul_a and mul_b hold until the next ISSUE.
- WAIT:
  - Wait for mul_done; there is no timeout.
  - On mul_done: acc <= acc + mul_result (32-bit signed, wraps modulo 2^32) and idx <= idx + 1.
  - If idx + 1 == len, go to RESP; otherwise go to ISSUE.
- RESP:
  - res_valid = 1, res_data = acc.
  - Both stay stable until res_ready is sampled high, then go to IDLE.
- Handshake rules:
  - res_valid never deasserts without res_ready.
  - A new command may be accepted at the earliest on the cycle after the RESP handshake.
- Latency with the matrix_multiplier (start to done = 2 cycles):
  - Per element: ISSUE 1 cycle + WAIT 2 cycles = 3 cycles.
  - cmd accept to res_valid = 1 + 3·len cycles (len > 0); 1 cycle for len == 0.
- Spurious inputs: mul_done outside WAIT is ignored; cmd_valid outside IDLE is ignored.
- Reset mid-operation: abort immediately to the reset state. No partial result is emitted.
- Width rules: product is already truncated to 32 bits by the multiplier; the accumulator is 32 bits.

Optional Feature:
- Macro: DOT_PRODUCT_SAT_EN.
- Defined: the accumulate saturates instead of wrapping.
  - Signed overflow clamps to 32'h7FFF_FFFF; underflow clamps to 32'h8000_0000.
  - Saturation is sticky: an extra output port sat_flag (1 bit) is set when any clamp occurs during the command.
  - sat_flag is valid alongside res_valid and clears on cmd accept or reset.
- Undefined: the accumulate wraps and the sat_flag port is absent.

Decomposition:
- Shared package dot_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Constants SAT_MAX = 32'h7FFF_FFFF and SAT_MIN = 32'h8000_0000.
  - DATA_W = 32.
- One sub-module, dp_accumulator: 32-bit signed add with clear/enable, wrap or saturate per DOT_PRODUCT_SAT_EN, producing sat_flag.
- Operand buffers and FSM stay in the top module.

Test Plan:
- Basic dot product: A = {1,2,3,4}, B = {5,6,7,8}, cmd_len = 4, multiplier model with 2-cycle done -> res_data = 70, res_valid 13 cycles after accept, exactly 4 mul_start pulses.
- Signed operands: A = {-3,7}, B = {4,-2}, len = 2 -> res_data = 32'hFFFF_FFE6 (-26).
- Zero length and clamp:
  - cmd_len = 0 -> res_valid the next cycle with res_data = 0 and no mul_start.
  - cmd_len = VEC_LEN+1 -> exactly VEC_LEN products are issued.
- Backpressure: hold res_ready low 10 cycles -> res_valid and res_data stable, cmd_ready low; the result drops one cycle after res_ready rises.
- Reset mid-WAIT: pull reset_n low during WAIT -> all outputs return to reset values the same cycle; a subsequent command with len = 1, A = B = 9 gives 81.
- Overflow: A = {32'h4000_0000, 1}, B = {1, 32'h4000_0000}:
  - Macro undefined -> res_data = 32'h8000_0000.
  - DOT_PRODUCT_SAT_EN defined -> res_data = 32'h7FFF_FFFF and sat_flag = 1.

Source files
------------

// File: rtl/dot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dot_pkg
//  Description : Shared types and constants for the dot-product sequencer:
//                FSM state encoding, data width and saturation limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package dot_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage : dot_pkg
`default_nettype wire

// File: rtl/dp_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : dp_accumulator
//  Description : 32-bit signed accumulator with synchronous clear and enable.
//                Wraps modulo 2^32 by default; with DOT_PRODUCT_SAT_EN defined
//                it clamps on signed overflow/underflow and raises a sticky
//                saturation flag that clears together with the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_accumulator
    import dot_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_addend,
    output logic [DATA_W-1:0] o_acc
`ifdef DOT_PRODUCT_SAT_EN
    ,
    output logic              o_sat_flag
`endif
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_sum;

    assign w_sum = r_acc + i_addend;
    assign o_acc = r_acc;

`ifdef DOT_PRODUCT_SAT_EN
    logic r_sat;
    logic w_ovf;
    logic w_unf;

    // Same-sign operands whose sum flips sign have left the signed range
    assign w_ovf = ~r_acc[DATA_W-1] & ~i_addend[DATA_W-1] &  w_sum[DATA_W-1];
    assign w_unf =  r_acc[DATA_W-1] &  i_addend[DATA_W-1] & ~w_sum[DATA_W-1];

    assign o_sat_flag = r_sat;

    // Saturating accumulate; clear wins over enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_enable) begin
            if (w_ovf) begin
                r_acc <= SAT_MAX;
                r_sat <= 1'b1;
            end else if (w_unf) begin
                r_acc <= SAT_MIN;
                r_sat <= 1'b1;
            end else begin
                r_acc <= w_sum;
            end
        end
    end
`else
    // Wrapping accumulate; clear wins over enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= w_sum;
        end
    end
`endif

endmodule : dp_accumulator
`default_nettype wire

// File: rtl/dot_product_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dot_product_sequencer
//  Description : Holds operand vectors A and B, feeds element pairs to a
//                scalar multiplier over a start/done handshake, accumulates
//                the products and returns one dot product per command over
//                a valid/ready handshake.
//                Optional macro DOT_PRODUCT_SAT_EN: saturating accumulate and
//                an extra sat_flag output.
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_product_sequencer
    import dot_pkg::*;
#(
    parameter int VEC_LEN = 8,
    parameter int IDX_W   = $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cmd_valid,
    input  logic [IDX_W:0]    cmd_len,
    output logic              cmd_ready,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_result,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic              busy
`ifdef DOT_PRODUCT_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam logic [IDX_W:0] c_vec_len = (IDX_W+1)'(VEC_LEN);
    localparam logic [IDX_W:0] c_one     = {{IDX_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_buf_a [VEC_LEN];
    logic [DATA_W-1:0] r_buf_b [VEC_LEN];

    state_t            r_state;
    logic [IDX_W:0]    r_idx;
    logic [IDX_W:0]    r_len;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_mul_start;
    logic [DATA_W-1:0] r_mul_a;
    logic [DATA_W-1:0] r_mul_b;
    logic              r_res_valid;

    logic [IDX_W:0]    w_len_clamped;
    logic [IDX_W:0]    w_idx_next;
    logic [IDX_W-1:0]  w_rd_addr;
    logic              w_accept;
    logic              w_acc_en;
    logic [DATA_W-1:0] w_acc;

    assign w_len_clamped = (cmd_len > c_vec_len) ? c_vec_len : cmd_len;
    assign w_idx_next    = r_idx + c_one;
    assign w_rd_addr     = w_idx_next[IDX_W-1:0];
    assign w_accept      = (r_state == IDLE) && cmd_valid;
    assign w_acc_en      = (r_state == WAIT) && mul_done;

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign res_valid = r_res_valid;
    // Accumulator only changes on accept or on a WAIT completion, so it is
    // stable for the whole RESP phase
    assign res_data  = w_acc;

    // Operand buffers: writable in every state, cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                r_buf_a[i] <= '0;
                r_buf_b[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_sel) begin
                r_buf_b[wr_addr] <= wr_data;
            end else begin
                r_buf_a[wr_addr] <= wr_data;
            end
        end
    end

    // Sequencer FSM; the start pulse and operands are loaded on the edge that
    // enters ISSUE so they are visible for exactly the ISSUE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_idx       <= '0;
                        r_len       <= w_len_clamped;
                        if (w_len_clamped == '0) begin
                            r_state     <= RESP;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_mul_start <= 1'b1;
                            r_mul_a     <= r_buf_a[0];
                            r_mul_b     <= r_buf_b[0];
                        end
                    end
                end
                ISSUE: begin
                    r_mul_start <= 1'b0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        r_idx <= w_idx_next;
                        if (w_idx_next == r_len) begin
                            r_state     <= RESP;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_mul_start <= 1'b1;
                            r_mul_a     <= r_buf_a[w_rd_addr];
                            r_mul_b     <= r_buf_b[w_rd_addr];
                        end
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    dp_accumulator u_acc (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_accept),
        .i_enable   (w_acc_en),
        .i_addend   (mul_result),
        .o_acc      (w_acc)
`ifdef DOT_PRODUCT_SAT_EN
        ,
        .o_sat_flag (sat_flag)
`endif
    );

endmodule : dot_product_sequencer
`default_nettype wire

// File: tb/tb_dot_product_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_product_sequencer
//  Description : Directed self-checking bench for dot_product_sequencer with
//                a 2-cycle multiplier model. Honours DOT_PRODUCT_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_product_sequencer;

    localparam int VEC_LEN = 8;
    localparam int IDX_W   = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic              wr_sel;
    logic [IDX_W-1:0]  wr_addr;
    logic [31:0]       wr_data;
    logic              cmd_valid;
    logic [IDX_W:0]    cmd_len;
    logic              cmd_ready;
    logic              mul_start;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic              mul_done;
    logic [31:0]       mul_result;
    logic              res_valid;
    logic [31:0]       res_data;
    logic              res_ready;
    logic              busy;
`ifdef DOT_PRODUCT_SAT_EN
    logic              sat_flag;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_starts = 0;

    // Multiplier model: done two cycles after start is raised
    logic        r_pipe;
    logic        r_mdl_done;
    logic [31:0] r_mdl_res;
    logic        spur_done;

    assign mul_done   = r_mdl_done | spur_done;
    assign mul_result = r_mdl_res;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe     <= 1'b0;
            r_mdl_done <= 1'b0;
            r_mdl_res  <= '0;
        end else begin
            r_pipe     <= mul_start;
            r_mdl_done <= r_pipe;
            if (r_pipe) r_mdl_res <= 32'($signed(mul_a) * $signed(mul_b));
        end
    end

    always @(posedge clk) begin
        if (mul_start) n_starts <= n_starts + 1;
    end

    dot_product_sequencer #(.VEC_LEN(VEC_LEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy)
`ifdef DOT_PRODUCT_SAT_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_buf(input logic sel, input int addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = IDX_W'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Issue a command and count cycles from the accept edge to res_valid
    task automatic run_cmd(input int len, output int lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = (IDX_W+1)'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept_result(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_res_valid_drop"}, {31'b0, res_valid}, 32'd0);
        check({tag, "_cmd_ready_back"}, {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int base;
        logic [31:0] held;

        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        res_ready = 1'b0;
        spur_done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_mul_start", {31'b0, mul_start}, 32'd0);
        check("rst_res_data",  res_data,           32'd0);
        reset_n = 1'b1;

        // Basic: {1,2,3,4}.{5,6,7,8} = 70
        for (int i = 0; i < 4; i++) begin
            write_buf(1'b0, i, 32'(i + 1));
            write_buf(1'b1, i, 32'(i + 5));
        end
        // A stray done while idle must be ignored
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        base = n_starts;
        run_cmd(4, lat);
        check("basic_latency", 32'(lat), 32'd13);
        check("basic_result",  res_data, 32'd70);
        check("basic_starts",  32'(n_starts - base), 32'd4);
        check("basic_busy",    {31'b0, busy},      32'd1);
        check("basic_cmd_rdy", {31'b0, cmd_ready}, 32'd0);
        accept_result("basic");

        // Signed operands: (-3*4) + (7*-2) = -26
        write_buf(1'b0, 0, -32'sd3);
        write_buf(1'b0, 1, 32'sd7);
        write_buf(1'b1, 0, 32'sd4);
        write_buf(1'b1, 1, -32'sd2);
        run_cmd(2, lat);
        check("signed_latency", 32'(lat), 32'd7);
        check("signed_result",  res_data, 32'hFFFF_FFE6);
        accept_result("signed");

        // Zero length: immediate response, no multiplier traffic
        base = n_starts;
        run_cmd(0, lat);
        check("zero_latency", 32'(lat), 32'd1);
        check("zero_result",  res_data, 32'd0);
        check("zero_starts",  32'(n_starts - base), 32'd0);
        accept_result("zero");

        // Over-length: A[i]=i+1, B[i]=1 -> clamped to 8 elements, sum 36
        for (int i = 0; i < VEC_LEN; i++) begin
            write_buf(1'b0, i, 32'(i + 1));
            write_buf(1'b1, i, 32'd1);
        end
        base = n_starts;
        run_cmd(VEC_LEN + 1, lat);
        check("clamp_latency", 32'(lat), 32'd25);
        check("clamp_starts",  32'(n_starts - base), 32'd8);
        check("clamp_result",  res_data, 32'd36);
        accept_result("clamp");

        // Backpressure, with a stray done during ISSUE and a stray command in RESP
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = 4'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        lat = 2;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp_result", res_data, 32'd3);
        held = res_data;
        cmd_valid = 1'b1;
        cmd_len   = 4'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid_held", {31'b0, res_valid}, 32'd1);
            check("bp_data_held",  res_data, held);
            check("bp_cmd_ready",  {31'b0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        accept_result("bp");

        // Reset during WAIT aborts immediately
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy_before", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("midrst_busy",      {31'b0, busy},      32'd0);
        check("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        check("midrst_mul_a",     mul_a,              32'd0);
        check("midrst_res_data",  res_data,           32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        // Buffers were cleared by reset
        run_cmd(1, lat);
        check("postrst_cleared", res_data, 32'd0);
        accept_result("postrst0");
        write_buf(1'b0, 0, 32'd9);
        write_buf(1'b1, 0, 32'd9);
        run_cmd(1, lat);
        check("postrst_latency", 32'(lat), 32'd4);
        check("postrst_result",  res_data, 32'd81);
        accept_result("postrst");

        // Overflow: 0x4000_0000 + 0x4000_0000
        write_buf(1'b0, 0, 32'h4000_0000);
        write_buf(1'b0, 1, 32'd1);
        write_buf(1'b1, 0, 32'd1);
        write_buf(1'b1, 1, 32'h4000_0000);
        run_cmd(2, lat);
`ifdef DOT_PRODUCT_SAT_EN
        check("ovf_result", res_data, 32'h7FFF_FFFF);
        check("ovf_sat",    {31'b0, sat_flag}, 32'd1);
        accept_result("ovf");
        run_cmd(0, lat);
        check("sat_clear_on_accept", {31'b0, sat_flag}, 32'd0);
        accept_result("satclr");
`else
        check("ovf_result", res_data, 32'h8000_0000);
        accept_result("ovf");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dot_product_sequencer
`default_nettype wire
